// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the fetch/LSU memory port arbiter
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_WAIT  = 2'd1,
    LSU_WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - 8-bit wait-state watchdog used when MEM_ARB_TIMEOUT_EN is defined
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = mem_arb_pkg::TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  // Count value seen in the last permitted wait cycle.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count;

  // Count wait cycles; cleared whenever the arbiter sits in IDLE.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count <= 8'd0;
    end else if (i_clear) begin
      count <= 8'd0;
    end else if (i_enable) begin
      count <= count + 8'd1;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th consecutive wait cycle.
  assign o_expire = i_enable && (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/LSU arbiter onto one memory port; optional watchdog via MEM_ARB_TIMEOUT_EN
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_valid,
  output logic              o_if_stall,
  input  logic              i_lsu_req,
  input  logic              i_lsu_wren,
  input  logic [ADDR_W-1:0] i_lsu_addr,
  input  logic [DATA_W-1:0] i_lsu_wdata,
  input  logic [3:0]        i_lsu_bmask,
  output logic [DATA_W-1:0] o_lsu_rdata,
  output logic              o_lsu_valid,
  output logic              o_lsu_stall,
  output logic              o_mem_req,
  output logic              o_mem_wren,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_timeout
);

  arb_state_t state, state_next;
  logic       grant_if, grant_lsu;
  logic       done, abort;
  logic       drop;
  logic       wd_expire;
  logic       drop_now;

  // A requester whose valid is pulsing still holds req for this cycle;
  // the stall terms double as "request not yet served".
  assign o_if_stall  = i_if_req  & ~o_if_valid;
  assign o_lsu_stall = i_lsu_req & ~o_lsu_valid;

  // A flush in the completing cycle drops the fetch just like an earlier one.
  assign drop_now = drop | i_flush;

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: LSU wins ties; a wait ends on ack, or on watchdog expiry.
  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_lsu  = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (o_lsu_stall) begin
          state_next = LSU_WAIT;
          grant_lsu  = 1'b1;
        end else if (o_if_stall && !i_flush) begin
          state_next = IF_WAIT;
          grant_if   = 1'b1;
        end
      end
      IF_WAIT, LSU_WAIT: begin
        if (i_mem_ack) begin
          state_next = IDLE;
          done       = 1'b1;
        end else if (wd_expire) begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus request/fields, read-data capture and completion pulses.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_mem_req   <= 1'b0;
      o_mem_wren  <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_bmask <= 4'h0;
      o_if_rdata  <= '0;
      o_lsu_rdata <= '0;
      o_if_valid  <= 1'b0;
      o_lsu_valid <= 1'b0;
    end else begin
      o_if_valid  <= 1'b0;
      o_lsu_valid <= 1'b0;
      if (grant_lsu) begin
        o_mem_req   <= 1'b1;
        o_mem_wren  <= i_lsu_wren;
        o_mem_addr  <= i_lsu_addr;
        o_mem_wdata <= i_lsu_wdata;
        o_mem_bmask <= i_lsu_bmask;
      end else if (grant_if) begin
        o_mem_req   <= 1'b1;
        o_mem_wren  <= 1'b0;
        o_mem_addr  <= i_if_addr;
        o_mem_wdata <= '0;
        o_mem_bmask <= 4'hF;
      end
      if (done || abort) begin
        o_mem_req <= 1'b0;
        if (state == IF_WAIT) begin
          o_if_rdata <= done ? i_mem_rdata : '0;
          o_if_valid <= ~drop_now;
        end else begin
          o_lsu_rdata <= done ? i_mem_rdata : '0;
          o_lsu_valid <= 1'b1;
        end
      end
    end
  end

  // Drop flag: set by a flush while a fetch is outstanding, cleared on completion.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      drop <= 1'b0;
    end else if (done || abort || state == IDLE) begin
      drop <= 1'b0;
    end else if (state == IF_WAIT && i_flush) begin
      drop <= 1'b1;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (state == IDLE),
    .i_enable (state != IDLE),
    .o_expire (wd_expire)
  );

  // Sticky timeout flag, only cleared by reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_timeout <= 1'b0;
    end else if (abort) begin
      o_timeout <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign wd_expire  = 1'b0;
  assign o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_reset, i_flush;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic [DW-1:0] o_if_rdata;
  logic          o_if_valid, o_if_stall;
  logic          i_lsu_req, i_lsu_wren;
  logic [AW-1:0] i_lsu_addr;
  logic [DW-1:0] i_lsu_wdata;
  logic [3:0]    i_lsu_bmask;
  logic [DW-1:0] o_lsu_rdata;
  logic          o_lsu_valid, o_lsu_stall;
  logic          o_mem_req, o_mem_wren;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [3:0]    o_mem_bmask;
  logic          i_mem_ack;
  logic [DW-1:0] i_mem_rdata;
  logic          o_timeout;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_flush     (i_flush),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_rdata  (o_if_rdata),
    .o_if_valid  (o_if_valid),
    .o_if_stall  (o_if_stall),
    .i_lsu_req   (i_lsu_req),
    .i_lsu_wren  (i_lsu_wren),
    .i_lsu_addr  (i_lsu_addr),
    .i_lsu_wdata (i_lsu_wdata),
    .i_lsu_bmask (i_lsu_bmask),
    .o_lsu_rdata (o_lsu_rdata),
    .o_lsu_valid (o_lsu_valid),
    .o_lsu_stall (o_lsu_stall),
    .o_mem_req   (o_mem_req),
    .o_mem_wren  (o_mem_wren),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_bmask (o_mem_bmask),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_timeout   (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "bench timeout");
  end

  task automatic drive_next();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_flush = 1'b0;
    i_if_req = 1'b0; i_if_addr = '0;
    i_lsu_req = 1'b0; i_lsu_wren = 1'b0; i_lsu_addr = '0; i_lsu_wdata = '0; i_lsu_bmask = 4'h0;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    repeat (3) drive_next();
    sample();
    checks++;
    if ({o_mem_req, o_if_valid, o_lsu_valid, o_timeout} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b required 0000", {o_mem_req, o_if_valid, o_lsu_valid, o_timeout});
    end
    checks++;
    if (o_mem_addr !== 32'h0 || o_if_rdata !== 32'h0 || o_lsu_rdata !== 32'h0 || o_mem_bmask !== 4'h0) begin
      errors++; $display("FAIL reset_data: addr %h if_rdata %h lsu_rdata %h bmask %h, required all 0", o_mem_addr, o_if_rdata, o_lsu_rdata, o_mem_bmask);
    end
    drive_next();
    i_reset = 1'b1;
    sample();
  endtask

  task automatic test_fetch();
    drive_next(); i_if_req = 1'b1; i_if_addr = 32'h100;
    sample();
    checks++;
    if (o_if_stall !== 1'b1 || o_mem_req !== 1'b0) begin
      errors++; $display("FAIL fetch_n: stall %b mem_req %b, required 1 0", o_if_stall, o_mem_req);
    end
    drive_next(); i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0013;
    sample();
    checks++;
    if ({o_mem_req, o_mem_wren, o_mem_bmask, o_if_stall, o_if_valid} !== 8'b1_0_1111_1_0 || o_mem_addr !== 32'h100) begin
      errors++; $display("FAIL fetch_n1: req %b wren %b bmask %h stall %b valid %b addr %h, required 1 0 f 1 0 100",
                         o_mem_req, o_mem_wren, o_mem_bmask, o_if_stall, o_if_valid, o_mem_addr);
    end
    drive_next(); i_mem_ack = 1'b0; i_mem_rdata = 32'hFFFF_FFFF;
    sample();
    checks++;
    if (o_if_valid !== 1'b1 || o_if_rdata !== 32'h13 || o_mem_req !== 1'b0 || o_if_stall !== 1'b0) begin
      errors++; $display("FAIL fetch_n2: valid %b rdata %h mem_req %b stall %b, required 1 13 0 0", o_if_valid, o_if_rdata, o_mem_req, o_if_stall);
    end
    drive_next(); i_if_req = 1'b0;
    sample();
    checks++;
    if (o_if_valid !== 1'b0 || o_mem_req !== 1'b0 || o_if_rdata !== 32'h13) begin
      errors++; $display("FAIL fetch_n3: valid %b mem_req %b rdata %h, required 0 0 13", o_if_valid, o_mem_req, o_if_rdata);
    end
  endtask

  task automatic test_priority();
    drive_next();
    i_if_req = 1'b1; i_if_addr = 32'h104;
    i_lsu_req = 1'b1; i_lsu_wren = 1'b0; i_lsu_addr = 32'h2000; i_lsu_bmask = 4'hF;
    sample();
    checks++;
    if (o_if_stall !== 1'b1 || o_lsu_stall !== 1'b1) begin
      errors++; $display("FAIL prio_stalls: if %b lsu %b, required 1 1", o_if_stall, o_lsu_stall);
    end
    drive_next(); i_mem_ack = 1'b1; i_mem_rdata = 32'hAAAA_5555;
    sample();
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h2000 || o_mem_wren !== 1'b0 || o_if_stall !== 1'b1) begin
      errors++; $display("FAIL prio_lsu_first: req %b addr %h wren %b if_stall %b, required 1 2000 0 1", o_mem_req, o_mem_addr, o_mem_wren, o_if_stall);
    end
    drive_next(); i_mem_ack = 1'b0;
    sample();
    checks++;
    if (o_lsu_valid !== 1'b1 || o_lsu_rdata !== 32'hAAAA_5555 || o_if_stall !== 1'b1 || o_mem_req !== 1'b0) begin
      errors++; $display("FAIL prio_lsu_done: valid %b rdata %h if_stall %b req %b, required 1 aaaa5555 1 0", o_lsu_valid, o_lsu_rdata, o_if_stall, o_mem_req);
    end
    drive_next(); i_lsu_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0093;
    sample();
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h104 || o_mem_bmask !== 4'hF || o_if_stall !== 1'b1 || o_lsu_valid !== 1'b0) begin
      errors++; $display("FAIL prio_fetch_issue: req %b addr %h bmask %h if_stall %b lsu_valid %b, required 1 104 f 1 0",
                         o_mem_req, o_mem_addr, o_mem_bmask, o_if_stall, o_lsu_valid);
    end
    drive_next(); i_mem_ack = 1'b0;
    sample();
    checks++;
    if (o_if_valid !== 1'b1 || o_if_rdata !== 32'h93) begin
      errors++; $display("FAIL prio_fetch_done: valid %b rdata %h, required 1 93", o_if_valid, o_if_rdata);
    end
    drive_next(); i_if_req = 1'b0;
    sample();
  endtask

  task automatic test_timeout();
`ifdef MEM_ARB_TIMEOUT_EN
    drive_next(); i_lsu_req = 1'b1; i_lsu_wren = 1'b0; i_lsu_addr = 32'h5000;
    for (int c = 1; c <= 4; c++) begin
      drive_next();
      sample();
      checks++;
      if (o_mem_req !== 1'b1 || o_timeout !== 1'b0 || o_lsu_valid !== 1'b0) begin
        errors++; $display("FAIL timeout_wait_%0d: req %b timeout %b valid %b, required 1 0 0", c, o_mem_req, o_timeout, o_lsu_valid);
      end
    end
    drive_next();
    sample();
    checks++;
    if (o_mem_req !== 1'b0 || o_lsu_valid !== 1'b1 || o_lsu_rdata !== 32'h0 || o_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_abort: req %b valid %b rdata %h timeout %b, required 0 1 0 1", o_mem_req, o_lsu_valid, o_lsu_rdata, o_timeout);
    end
    drive_next(); i_lsu_req = 1'b0;
    repeat (3) drive_next();
    sample();
    checks++;
    if (o_timeout !== 1'b1 || o_lsu_valid !== 1'b0 || o_mem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky: timeout %b valid %b req %b, required 1 0 0", o_timeout, o_lsu_valid, o_mem_req);
    end
`else
    drive_next(); i_lsu_req = 1'b1; i_lsu_wren = 1'b0; i_lsu_addr = 32'h5000;
    repeat (20) drive_next();
    sample();
    checks++;
    if (o_mem_req !== 1'b1 || o_timeout !== 1'b0 || o_lsu_valid !== 1'b0) begin
      errors++; $display("FAIL no_timeout_wait: req %b timeout %b valid %b, required 1 0 0", o_mem_req, o_timeout, o_lsu_valid);
    end
    drive_next(); i_mem_ack = 1'b1; i_mem_rdata = 32'h0;
    drive_next(); i_mem_ack = 1'b0;
    sample();
    checks++;
    if (o_lsu_valid !== 1'b1 || o_lsu_rdata !== 32'h0) begin
      errors++; $display("FAIL no_timeout_done: valid %b rdata %h, required 1 0", o_lsu_valid, o_lsu_rdata);
    end
    drive_next(); i_lsu_req = 1'b0;
    sample();
`endif
  endtask

  task automatic test_store();
    drive_next();
    i_lsu_req = 1'b1; i_lsu_wren = 1'b1; i_lsu_addr = 32'h3000;
    i_lsu_wdata = 32'hDEAD_BEEF; i_lsu_bmask = 4'b0011;
    for (int c = 1; c <= 3; c++) begin
      drive_next();
      if (c == 3) begin
        i_mem_ack = 1'b1; i_mem_rdata = 32'h1234_5678;
      end
      sample();
      checks++;
      if ({o_mem_req, o_mem_wren, o_mem_bmask} !== 6'b1_1_0011 || o_mem_addr !== 32'h3000 ||
          o_mem_wdata !== 32'hDEAD_BEEF || o_lsu_valid !== 1'b0 || o_lsu_stall !== 1'b1) begin
        errors++; $display("FAIL store_hold_%0d: req %b wren %b bmask %b addr %h wdata %h valid %b, required 1 1 0011 3000 deadbeef 0",
                           c, o_mem_req, o_mem_wren, o_mem_bmask, o_mem_addr, o_mem_wdata, o_lsu_valid);
      end
    end
    drive_next(); i_mem_ack = 1'b0;
    sample();
    checks++;
    if (o_lsu_valid !== 1'b1 || o_mem_req !== 1'b0 || o_lsu_stall !== 1'b0) begin
      errors++; $display("FAIL store_done: valid %b req %b stall %b, required 1 0 0", o_lsu_valid, o_mem_req, o_lsu_stall);
    end
    drive_next(); i_lsu_req = 1'b0; i_lsu_wren = 1'b0;
    sample();
    checks++;
    if (o_lsu_valid !== 1'b0 || o_mem_req !== 1'b0) begin
      errors++; $display("FAIL store_one_pulse: valid %b req %b, required 0 0", o_lsu_valid, o_mem_req);
    end
  endtask

  task automatic test_flush();
    drive_next(); i_if_req = 1'b1; i_if_addr = 32'h200;
    drive_next(); i_flush = 1'b1;
    sample();
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h200) begin
      errors++; $display("FAIL flush_issue: req %b addr %h, required 1 200", o_mem_req, o_mem_addr);
    end
    drive_next(); i_flush = 1'b0;
    drive_next(); i_mem_ack = 1'b1; i_mem_rdata = 32'hBAD0_BAD0;
    sample();
    checks++;
    if (o_mem_req !== 1'b1) begin
      errors++; $display("FAIL flush_still_on_bus: req %b, required 1", o_mem_req);
    end
    drive_next(); i_mem_ack = 1'b0; i_if_addr = 32'h300;
    sample();
    checks++;
    if (o_if_valid !== 1'b0 || o_mem_req !== 1'b0 || o_if_stall !== 1'b1) begin
      errors++; $display("FAIL flush_suppressed: valid %b req %b stall %b, required 0 0 1", o_if_valid, o_mem_req, o_if_stall);
    end
    drive_next(); i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0055;
    sample();
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h300) begin
      errors++; $display("FAIL flush_refetch: req %b addr %h, required 1 300", o_mem_req, o_mem_addr);
    end
    drive_next(); i_mem_ack = 1'b0;
    sample();
    checks++;
    if (o_if_valid !== 1'b1 || o_if_rdata !== 32'h55) begin
      errors++; $display("FAIL flush_refetch_done: valid %b rdata %h, required 1 55", o_if_valid, o_if_rdata);
    end
    drive_next(); i_if_req = 1'b0;
    sample();
  endtask

  task automatic test_reset_mid();
    drive_next(); i_lsu_req = 1'b1; i_lsu_wren = 1'b0; i_lsu_addr = 32'h4000;
    drive_next();
    sample();
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h4000) begin
      errors++; $display("FAIL rst_mid_issue: req %b addr %h, required 1 4000", o_mem_req, o_mem_addr);
    end
    drive_next(); i_reset = 1'b0;
    #1;
    checks++;
    if (o_mem_req !== 1'b0 || o_mem_addr !== 32'h0 || o_timeout !== 1'b0) begin
      errors++; $display("FAIL rst_mid_immediate: req %b addr %h timeout %b, required 0 0 0", o_mem_req, o_mem_addr, o_timeout);
    end
    drive_next(); i_reset = 1'b1; i_lsu_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
    drive_next(); i_mem_ack = 1'b0;
    sample();
    checks++;
    if (o_lsu_valid !== 1'b0 || o_if_valid !== 1'b0 || o_mem_req !== 1'b0 || o_lsu_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_late_ack: lsu_valid %b if_valid %b req %b rdata %h, required 0 0 0 0",
                         o_lsu_valid, o_if_valid, o_mem_req, o_lsu_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_timeout();
    test_store();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width; TIMEOUT_CYCLES, default 255, watchdog limit (8-bit).
REQ-002 SHALL have ports (name  direction  width  meaning):
 i_clk  in  1  single clock, all state on rising edge
 i_reset  in  1  asynchronous, active-low reset
 i_flush  in  1  branch-taken flush from hazard logic
 i_if_req  in  1  fetch request, held until o_if_valid
 i_if_addr  in  ADDR_W  fetch address
 o_if_rdata  out  DATA_W  fetched instruction
 o_if_valid  out  1  one-cycle fetch completion pulse
 o_if_stall  out  1  fetch stall to PC / IF-ID
 i_lsu_req  in  1  data request, held until o_lsu_valid
 i_lsu_wren  in  1  1 = store, 0 = load
 i_lsu_addr  in  ADDR_W  data address
 i_lsu_wdata  in  DATA_W  store data
 i_lsu_bmask  in  4  store byte enables
 o_lsu_rdata  out  DATA_W  load data
 o_lsu_valid  out  1  one-cycle data completion pulse
 o_lsu_stall  out  1  stall to MEM stage
 o_mem_req  out  1  shared memory request, held until ack
 o_mem_wren  out  1  shared memory write enable
 o_mem_addr  out  ADDR_W  shared memory address
 o_mem_wdata  out  DATA_W  shared memory write data
 o_mem_bmask  out  4  shared memory byte enables
 i_mem_ack  in  1  one-cycle memory completion
 i_mem_rdata  in  DATA_W  memory read data, valid with ack
 o_timeout  out  1  sticky watchdog error

Function
REQ-003 SHALL implement FSM states IDLE, IF_WAIT, LSU_WAIT, with one outstanding memory transaction at a time.
REQ-004 In IDLE: i_lsu_req SHALL go to LSU_WAIT; otherwise i_if_req && !i_flush SHALL go to IF_WAIT; LSU has fixed priority when both request.
REQ-005 On leaving IDLE, the arbiter SHALL register the winner's addr/wren/wdata/bmask onto o_mem_*, and SHALL assert o_mem_req from the next cycle until the i_mem_ack cycle inclusive.
REQ-006 For fetch, o_mem_wren SHALL be 0 and o_mem_bmask SHALL be 4'hF.
REQ-007 On i_mem_ack in a WAIT state: capture i_mem_rdata into the owner's rdata register; pulse the owner's valid the next cycle; return to IDLE. Minimum latency: req in cycle N, o_mem_req in N+1, valid in N+2 if acked in N+1.
REQ-008 i_mem_ack outside a WAIT state SHALL be ignored.
REQ-009 o_if_stall SHALL equal i_if_req & ~o_if_valid; o_lsu_stall SHALL equal i_lsu_req & ~o_lsu_valid (combinational).
REQ-010 i_flush asserted in IF_WAIT, or in the ack cycle, SHALL set a drop flag. The transaction still completes on the bus; o_if_valid is suppressed; the flag clears on return to IDLE.
REQ-011 i_flush SHALL NOT affect LSU transactions.
REQ-012 After completion, IDLE SHALL accept a new request in the cycle after the return to IDLE; there are no back-to-back grants without passing through IDLE.
REQ-013 o_if_rdata and o_lsu_rdata SHALL hold their last value between completions.

Reset
REQ-014 While i_reset = 0: state IDLE; o_mem_req, o_if_valid, o_lsu_valid, and o_timeout = 0; all data/addr registers 0; drop flag and watchdog cleared. These are forced immediately, including mid-transaction.
REQ-015 An ack arriving in the first cycle after reset release SHALL be ignored.

Configuration
REQ-016 Macro MEM_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL count cycles in a WAIT state. When it reaches TIMEOUT_CYCLES without ack: abort (o_mem_req=0), pulse the owner's valid with rdata 0 (a dropped fetch stays suppressed), set o_timeout sticky until reset, return to IDLE.
REQ-017 Macro undefined: no counter SHALL exist, o_timeout SHALL be tied 0, and WAIT states SHALL wait indefinitely.

Structure
REQ-018 Package mem_arb_pkg SHALL hold the state enum, default widths, and the TIMEOUT_CYCLES default.
REQ-019 The watchdog SHALL be sub-module mem_arb_watchdog (clear, enable, expire), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-020 Fetch addr 0x100, ack in first bus cycle -> o_mem_req for 1 cycle, o_if_valid at N+2 with rdata = ack data, o_if_stall high N..N+1.
REQ-021 Simultaneous if_req and lsu load 0x2000 -> LSU served first; fetch issued after return to IDLE; o_if_stall high throughout.
REQ-022 Store 0xDEADBEEF, bmask 4'b0011, ack after 3 cycles -> o_mem_* stable for 3 cycles, wren=1, o_lsu_valid one pulse.
REQ-023 i_flush in IF_WAIT, ack 2 cycles later -> no o_if_valid; a new fetch is accepted the cycle after return to IDLE.
REQ-024 i_reset low mid-LSU_WAIT -> o_mem_req low at once; a late ack after release produces no valid.
REQ-025 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> abort at cycle 4, o_lsu_valid with rdata 0, o_timeout stays 1 until reset.
